// File: rtl/sum_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and a
// ceiling-log2 helper used to size the bit-step counter.
package sum_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Smallest r with 2**r >= v; used for counter width (v >= 2).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_add_cell.sv
// Single-bit full adder cell, purely combinational.
// Ports: x, y - operand bits; ci - carry in; s - sum bit; co - carry out.
module full_add_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/sum_nbits_serial.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, one bit per clock, LSB
// first, with start/busy/done handshake, carry-in, carry-out and signed
// overflow.
// Ports:
//   clk, rst_n        - clock (rising edge), async active-low reset
//   start             - request, honoured only in IDLE or DONE
//   a, b, cin         - operands and carry-in, captured on accepted start
//   busy              - high while bits are being stepped (RUN)
//   done              - one-cycle pulse when s/cout/ovf are updated
//   s, cout, ovf      - sum, carry out of MSB, signed overflow (held)
module sum_nbits_serial
  import sum_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d;
  logic [WIDTH-1:0] s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, c_msb_q, c_msb_d;
  logic             busy_d, done_d, cout_d, ovf_d;
  logic             sum_bit, c_next;

  // The only adder: operates on the current LSBs and the running carry.
  full_add_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (sum_bit),
    .co (c_next)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    s_d     = s;
    cout_d  = cout;
    ovf_d   = ovf;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sr_d    = {sum_bit, sr_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = c_next;
        cnt_d   = cnt_q + CW'(1);
        // Carry generated by bit WIDTH-2 is the carry into the MSB.
        if (cnt_q == CNT_MSB) c_msb_d = c_next;
        if (cnt_q == CNT_LAST) begin
          s_d     = {sum_bit, sr_q[WIDTH-1:1]};
          cout_d  = c_next;
          ovf_d   = c_msb_q ^ c_next;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      busy    <= busy_d;
      done    <= done_d;
      s       <= s_d;
      cout    <= cout_d;
      ovf     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sum_nbits_serial.sv
// Scoreboard bench for sum_nbits_serial: a WIDTH=4 and a WIDTH=8 instance.
// Drivers push arithmetic expectations; a monitor pops them on done.
module tb_sum_nbits_serial;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        st [2];
  logic [31:0] av [2];
  logic [31:0] bv [2];
  logic        ci [2];

  logic        bsy4, dn4, co4, ov4, bsy8, dn8, co8, ov8;
  logic [3:0]  s4;
  logic [7:0]  s8;
  logic        bz [2];
  logic        dn [2];
  logic        co [2];
  logic        ov [2];
  logic [31:0] sv [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] hold  [2];
  int          brun  [2];
  logic        pbusy [2];
  logic        pdone [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sum_nbits_serial #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0][3:0]), .b(bv[0][3:0]),
    .cin(ci[0]), .busy(bsy4), .done(dn4), .s(s4), .cout(co4), .ovf(ov4)
  );

  sum_nbits_serial #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][7:0]), .b(bv[1][7:0]),
    .cin(ci[1]), .busy(bsy8), .done(dn8), .s(s8), .cout(co8), .ovf(ov8)
  );

  always_comb begin
    bz[0] = bsy4; dn[0] = dn4; co[0] = co4; ov[0] = ov4; sv[0] = 32'(s4);
    bz[1] = bsy8; dn[1] = dn8; co[1] = co8; ov[1] = ov8; sv[1] = 32'(s8);
  end

  function automatic int wd(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  // Reference: plain unsigned and signed arithmetic on the operands.
  function automatic exp_t model(input int w, input longint a, input longint b,
                                 input longint c, input int dcyc);
    exp_t   e;
    longint u, sa, sb, ss, half;
    half   = longint'(1) << (w - 1);
    u      = a + b + c;
    e.s    = 32'(u & ((longint'(1) << w) - 1));
    e.cout = 1'((u >> w) & 1);
    sa     = (a >= half) ? a - 2 * half : a;
    sb     = (b >= half) ? b - 2 * half : b;
    ss     = sa + sb + c;
    e.ovf  = (ss > half - 1) || (ss < -half);
    e.cyc  = dcyc;
    return e;
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon(input int i);
    exp_t  e;
    string p;
    p = $sformatf("w%0d_", wd(i));
    if (dn[i]) begin
      if (qsize(i) == 0) begin
        chk({p, "unexpected_done"}, 1, 0);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk({p, "s"}, sv[i], e.s);
        chk({p, "cout"}, co[i], e.cout);
        chk({p, "ovf"}, ov[i], e.ovf);
        chk({p, "done_latency"}, cyc, e.cyc);
        hold[i] = e.s;
      end
      chk({p, "done_with_busy"}, bz[i], 0);
      chk({p, "done_width"}, pdone[i], 0);
    end else if (bz[i]) begin
      chk({p, "s_hold"}, sv[i], hold[i]);
    end
    if (bz[i]) begin
      brun[i]++;
    end else if (pbusy[i]) begin
      chk({p, "busy_len"}, brun[i], wd(i));
      brun[i] = 0;
    end
    pbusy[i] = bz[i];
    pdone[i] = dn[i];
  endtask

  always @(negedge clk) begin
    if (rst_n) for (int i = 0; i < 2; i++) mon(i);
  end

  // Present one operation as a one-cycle start at the next accepting cycle.
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic c);
    int          k;
    logic [31:0] m;
    m = (32'd1 << wd(i)) - 32'd1;
    k = 0;
    @(negedge clk);
    while (bz[i] && k < 50) begin @(negedge clk); k++; end
    if (bz[i]) begin chk("accept_timeout", 1, 0); return; end
    av[i] = a & m; bv[i] = b & m; ci[i] = c; st[i] = 1'b1;
    push(i, model(wd(i), longint'(a & m), longint'(b & m), longint'(c), cyc + wd(i) + 1));
    @(negedge clk);
    st[i] = 1'b0;
    av[i] = $urandom; bv[i] = $urandom; ci[i] = 1'($urandom);
  endtask

  // Start held high for n accepted operations.
  task automatic held(input int i, input int n);
    int          k;
    logic [31:0] m;
    m = (32'd1 << wd(i)) - 32'd1;
    for (int j = 0; j < n; j++) begin
      k = 0;
      @(negedge clk);
      while (bz[i] && k < 50) begin
        av[i] = $urandom; bv[i] = $urandom; ci[i] = 1'($urandom);
        @(negedge clk); k++;
      end
      if (bz[i]) begin chk("held_timeout", 1, 0); break; end
      av[i] = $urandom & m; bv[i] = $urandom & m; ci[i] = 1'($urandom); st[i] = 1'b1;
      push(i, model(wd(i), longint'(av[i]), longint'(bv[i]), longint'(ci[i]),
                    cyc + wd(i) + 1));
    end
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int k;
    k = 0;
    while (qsize(i) > 0 && k < 200) begin @(negedge clk); k++; end
    if (qsize(i) > 0) begin
      chk("drain_timeout", qsize(i), 0);
      if (i == 0) q0.delete(); else q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input int i, input string tag);
    string p;
    p = $sformatf("w%0d_%s_", wd(i), tag);
    chk({p, "busy"}, bz[i], 0);
    chk({p, "done"}, dn[i], 0);
    chk({p, "s"}, sv[i], 0);
    chk({p, "cout"}, co[i], 0);
    chk({p, "ovf"}, ov[i], 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b1; av[i] = '0; bv[i] = '0; ci[i] = 1'b0;
      hold[i] = '0; brun[i] = 0; pbusy[i] = 1'b0; pdone[i] = 1'b0;
    end

    // Reset held with start high: everything stays quiet.
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_zero(0, "reset");
      chk_zero(1, "reset");
    end
    st[0] = 1'b0; st[1] = 1'b0;
    rst_n = 1'b1;

    // Directed WIDTH=4 cases, with start pulses during RUN after the first.
    issue(0, 32'h3, 32'h5, 1'b0);
    st[0] = 1'b1; av[0] = $urandom;
    @(negedge clk); st[0] = 1'b0;
    @(negedge clk); st[0] = 1'b1; bv[0] = $urandom;
    @(negedge clk); st[0] = 1'b0;
    issue(0, 32'hF, 32'h1, 1'b0);
    issue(0, 32'hF, 32'hF, 1'b1);
    issue(0, 32'h8, 32'h8, 1'b0);
    drain(0);

    // Back-to-back with start held high.
    held(0, 4);
    drain(0);

    // Abort mid-operation with an asynchronous reset.
    issue(0, 32'h3, 32'h5, 1'b0);
    drain(0);
    issue(0, 32'h6, 32'h7, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero(0, "abort");
    q0.delete();
    for (int i = 0; i < 2; i++) begin
      hold[i] = '0; brun[i] = 0; pbusy[i] = 1'b0; pdone[i] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) begin
      @(negedge clk);
      chk("w4_abort_no_done", dn[0], 0);
    end
    issue(0, 32'h6, 32'h7, 1'b0);
    drain(0);

    // Exhaustive WIDTH=4 sweep.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          issue(0, 32'(x), 32'(y), 1'(c));
    drain(0);

    // Randomised WIDTH=8 vectors plus a held-start burst.
    for (int n = 0; n < 1000; n++)
      issue(1, $urandom, $urandom, 1'($urandom));
    held(1, 3);
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_nbits_serial.md
Name: sum_nbits_serial

Overview:
Parametrised bit-serial adder. It generalises the team's 1-bit full adder with carry to WIDTH-bit operands: one full-adder cell, one bit per clock, LSB first. It has a start/busy/done handshake, a carry-in, and carry-out and signed-overflow flags. It sits as a compute slave under a simple controller that presents operands, pulses start and waits for done.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only when accepting (IDLE or DONE)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; s/cout/ovf valid from this cycle
s  output  WIDTH  sum a+b+cin mod 2^WIDTH, registered
cout  output  1  carry out of MSB
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE; busy=0, done=0, s=0, cout=0, ovf=0; internal shift registers, carry and counter cleared. Reset mid-RUN aborts the operation; no done is produced.
- States:
  - IDLE: busy=0, done=0. Moves to RUN on start=1.
  - RUN: busy=1. Moves to DONE after WIDTH bit steps.
  - DONE: done=1 for exactly one cycle. Moves to RUN if start=1, otherwise to IDLE.
- Accept, edge k (start=1 in IDLE or DONE): load A<=a, B<=b, carry<=cin, cnt<=0; state->RUN.
- Each RUN edge:
  - Full-adder cell computes sum_bit/c_next from A[0], B[0], carry.
  - Shift sum_bit into MSB of the internal sum shift register; shift A and B right.
  - carry<=c_next; cnt<=cnt+1.
  - On the step with cnt==WIDTH-2, record the carry into the MSB (c_msb).
- Completion, edge k+WIDTH (step with cnt==WIDTH-1):
  - s<=final shifted sum; cout<=c_next; ovf<=c_msb XOR c_next.
  - state->DONE.
- Latency: done high during cycle after edge k+WIDTH. busy high for exactly WIDTH cycles.
- s, cout and ovf change only at completion or reset. They hold the last result through IDLE, RUN and DONE until the next completion.
- start during RUN is ignored; no queueing. start held high continuously gives back-to-back operations with period WIDTH+1 cycles.
- a, b and cin may change freely after the accept edge without affecting the result.
- Counter width is clog2(WIDTH). cnt never exceeds WIDTH-1.
- No X on outputs after reset. Unused state encoding recovers to IDLE.

Decomposition:
- Shared package / include sum_serial_pkg:
  - state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - clog2 helper function for counter width.
- One sub-module: full_add_cell. Purely combinational (x, y, ci -> s, co); instantiated once.
- FSM, counter and shift registers stay in sum_nbits_serial.

Test Plan:
1. Reset: rst_n=0 for 3 cycles, start=1 -> busy=0, done=0, s=0, cout=0, ovf=0 throughout.
2. WIDTH=4, a=4'h3, b=4'h5, cin=0, one-cycle start:
   - busy=1 for exactly 4 cycles.
   - done pulse in 5th cycle after accept edge.
   - s=4'h8, cout=0, ovf=1.
3. WIDTH=4:
   - a=4'hF, b=4'h1, cin=0 -> s=4'h0, cout=1, ovf=0.
   - a=4'hF, b=4'hF, cin=1 -> s=4'hF, cout=1, ovf=0.
   - a=4'h8, b=4'h8, cin=0 -> s=4'h0, cout=1, ovf=1.
4. Handshake:
   - start pulses during RUN -> ignored, single done.
   - start held high -> done every 5 cycles.
   - Operands changed the cycle after accept -> result matches the captured values.
5. Reset mid-op: rst_n=0 after 2 RUN cycles of a=4'h6, b=4'h7 (prior result s=4'h8):
   - outputs zero immediately (asynchronous).
   - no done pulse.
   - next start of a=4'h6, b=4'h7 completes normally: s=4'hD, ovf=1.
6. Exhaustive sweep, WIDTH=4 and WIDTH=8 (WIDTH=8 randomised 1000 vectors): all a, b, cin for WIDTH=4 -> {cout,s}==a+b+cin, and ovf matches a signed reference model.
